// File: rtl/insight_dcache_resp_tracker.sv
// Tracks outstanding data-cache requests, matches responses by transaction id and
// emits latency-annotated, lane-formatted trace records through a 2-entry FIFO.
module insight_dcache_resp_tracker #(
  parameter int SLOTS = 8,
  parameter int LAT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid,
  input  logic [31:0]                req_addr,
  input  logic [5:0]                 req_id,
  input  logic [4:0]                 req_cmd,
  input  logic                       req_signed,
  input  logic [1:0]                 req_size,
  input  logic                       resp_valid,
  input  logic [5:0]                 resp_id,
  input  logic [31:0]                resp_data,
  output logic                       trc_valid,
  input  logic                       trc_ready,
  output logic [5:0]                 trc_id,
  output logic [31:0]                trc_addr,
  output logic [4:0]                 trc_cmd,
  output logic [31:0]                trc_data,
  output logic [LAT_W-1:0]           trc_latency,
  output logic                       trc_orphan,
  output logic [$clog2(SLOTS+1)-1:0] outstanding,
  output logic                       err_overflow,
  output logic                       err_dup_id,
  output logic                       err_drop
);

  localparam int IDX_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int CNT_W = $clog2(SLOTS + 1);

  localparam logic [4:0] M_XRD     = 5'b00000;
  localparam logic [4:0] M_XA_SWAP = 5'b00100;
  localparam logic [4:0] M_XLR     = 5'b00110;
  localparam logic [4:0] M_XSC     = 5'b00111;
  localparam logic [4:0] M_XA_ADD  = 5'b01000;
  localparam logic [4:0] M_XA_XOR  = 5'b01001;
  localparam logic [4:0] M_XA_OR   = 5'b01010;
  localparam logic [4:0] M_XA_AND  = 5'b01011;
  localparam logic [4:0] M_XA_MIN  = 5'b01100;
  localparam logic [4:0] M_XA_MAX  = 5'b01101;
  localparam logic [4:0] M_XA_MINU = 5'b01110;
  localparam logic [4:0] M_XA_MAXU = 5'b01111;

  typedef struct packed {
    logic [5:0]       id;
    logic [31:0]      addr;
    logic [4:0]       cmd;
    logic [31:0]      data;
    logic [LAT_W-1:0] latency;
    logic             orphan;
  } rec_t;

  function automatic logic is_resp_cmd(input logic [4:0] cmd);
    case (cmd)
      M_XRD, M_XLR, M_XSC, M_XA_SWAP, M_XA_ADD, M_XA_XOR, M_XA_OR, M_XA_AND,
      M_XA_MIN, M_XA_MAX, M_XA_MINU, M_XA_MAXU: is_resp_cmd = 1'b1;
      default:                                  is_resp_cmd = 1'b0;
    endcase
  endfunction

  function automatic logic [IDX_W-1:0] lowest_set(input logic [SLOTS-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = SLOTS - 1; i >= 0; i--) idx = v[i] ? IDX_W'(i) : idx;
    return idx;
  endfunction

  function automatic logic [CNT_W-1:0] count_ones(input logic [SLOTS-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < SLOTS; i++) n = n + CNT_W'(v[i]);
    return n;
  endfunction

  function automatic logic [31:0] load_format(input logic [31:0] data, input logic [1:0] addr_lo,
                                              input logic [1:0] size, input logic sgn);
    logic [31:0] shifted;
    case (size)
      2'd0: begin
        shifted     = data >> {addr_lo, 3'b000};
        load_format = {{24{sgn & shifted[7]}}, shifted[7:0]};
      end
      2'd1: begin
        shifted     = data >> {addr_lo[1], 4'b0000};
        load_format = {{16{sgn & shifted[15]}}, shifted[15:0]};
      end
      default: begin
        shifted     = data;
        load_format = shifted;
      end
    endcase
  endfunction

  logic [SLOTS-1:0] slot_valid_r;
  logic [5:0]       slot_id_r     [SLOTS];
  logic [31:0]      slot_addr_r   [SLOTS];
  logic [4:0]       slot_cmd_r    [SLOTS];
  logic             slot_signed_r [SLOTS];
  logic [1:0]       slot_size_r   [SLOTS];
  logic [LAT_W-1:0] slot_age_r    [SLOTS];

  logic [SLOTS-1:0] resp_match_s, req_match_s, valid_next_s;
  logic [IDX_W-1:0] hit_idx_s, free_idx_s;
  logic             req_live_s, hit_s, free_any_s, dup_s, alloc_s, ovf_s;
  logic [LAT_W-1:0] hit_age_s, hit_lat_s;
  rec_t             rec_s;

  // Compare incoming ids only against slots that were valid before this edge
  always_comb begin
    resp_match_s = '0;
    req_match_s  = '0;
    for (int i = 0; i < SLOTS; i++) begin
      resp_match_s[i] = slot_valid_r[i] && (slot_id_r[i] == resp_id);
      req_match_s[i]  = slot_valid_r[i] && (slot_id_r[i] == req_id);
    end
  end

  assign req_live_s = req_valid & is_resp_cmd(req_cmd);
  assign hit_s      = resp_valid & (|resp_match_s);
  assign hit_idx_s  = lowest_set(resp_match_s);
  assign free_idx_s = lowest_set(~slot_valid_r);
  assign free_any_s = |(~slot_valid_r);
  assign dup_s      = req_live_s & (|req_match_s);
  assign alloc_s    = req_live_s & ~dup_s & free_any_s;
  assign ovf_s      = req_live_s & ~dup_s & ~free_any_s;
  assign hit_age_s  = slot_age_r[hit_idx_s];
  // Latency counts the response cycle itself, so it is the stored age plus one
  assign hit_lat_s  = (&hit_age_s) ? hit_age_s : hit_age_s + LAT_W'(1);

  // A slot freed this edge is still marked used in free_idx_s, so it cannot be reused yet
  assign valid_next_s = (slot_valid_r & ~(SLOTS'(hit_s) << hit_idx_s)) | (SLOTS'(alloc_s) << free_idx_s);

  // Build the trace record for the response presented this cycle
  always_comb begin
    rec_s    = '0;
    rec_s.id = resp_id;
    if (hit_s) begin
      rec_s.addr    = slot_addr_r[hit_idx_s];
      rec_s.cmd     = slot_cmd_r[hit_idx_s];
      rec_s.latency = hit_lat_s;
      rec_s.orphan  = 1'b0;
      if ((slot_cmd_r[hit_idx_s] == M_XRD) || (slot_cmd_r[hit_idx_s] == M_XLR)) begin
        rec_s.data = load_format(resp_data, slot_addr_r[hit_idx_s][1:0],
                                 slot_size_r[hit_idx_s], slot_signed_r[hit_idx_s]);
      end else begin
        rec_s.data = resp_data;
      end
    end else begin
      rec_s.orphan = 1'b1;
      rec_s.data   = resp_data;
    end
  end

  // Slot table, ages, occupancy count and request-side error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_valid_r <= '0;
      outstanding  <= '0;
      err_overflow <= 1'b0;
      err_dup_id   <= 1'b0;
      for (int i = 0; i < SLOTS; i++) begin
        slot_id_r[i]     <= '0;
        slot_addr_r[i]   <= '0;
        slot_cmd_r[i]    <= '0;
        slot_signed_r[i] <= 1'b0;
        slot_size_r[i]   <= '0;
        slot_age_r[i]    <= '0;
      end
    end else begin
      slot_valid_r <= valid_next_s;
      outstanding  <= count_ones(valid_next_s);
      err_overflow <= err_overflow | ovf_s;
      err_dup_id   <= err_dup_id | dup_s;
      for (int i = 0; i < SLOTS; i++) begin
        if (alloc_s && (free_idx_s == IDX_W'(i))) begin
          slot_id_r[i]     <= req_id;
          slot_addr_r[i]   <= req_addr;
          slot_cmd_r[i]    <= req_cmd;
          slot_signed_r[i] <= req_signed;
          slot_size_r[i]   <= req_size;
          slot_age_r[i]    <= '0;
        end else if (slot_valid_r[i] && !(&slot_age_r[i])) begin
          slot_age_r[i] <= slot_age_r[i] + LAT_W'(1);
        end
      end
    end
  end

  rec_t head_r, buf_r, head_n, buf_n;
  logic head_valid_r, buf_valid_r, head_valid_n, buf_valid_n, pop_s, drop_s;

  assign pop_s = head_valid_r & trc_ready;

  // Two-entry record FIFO: head drives the trace outputs, buf holds the second record
  always_comb begin
    head_valid_n = head_valid_r;
    head_n       = head_r;
    buf_valid_n  = buf_valid_r;
    buf_n        = buf_r;
    drop_s       = 1'b0;
    case ({head_valid_r, buf_valid_r})
      2'b00: begin
        if (resp_valid) begin
          head_valid_n = 1'b1;
          head_n       = rec_s;
        end else begin
          head_valid_n = 1'b0;
        end
      end
      2'b10: begin
        if (pop_s && resp_valid) begin
          head_n = rec_s;
        end else if (pop_s) begin
          head_valid_n = 1'b0;
          head_n       = '0;
        end else if (resp_valid) begin
          buf_valid_n = 1'b1;
          buf_n       = rec_s;
        end else begin
          head_valid_n = 1'b1;
        end
      end
      2'b11: begin
        if (pop_s) begin
          head_n = buf_r;
          if (resp_valid) begin
            buf_n = rec_s;
          end else begin
            buf_valid_n = 1'b0;
            buf_n       = '0;
          end
        end else begin
          drop_s = resp_valid;
        end
      end
      default: begin
        head_valid_n = 1'b0;
        head_n       = '0;
        buf_valid_n  = 1'b0;
        buf_n        = '0;
      end
    endcase
  end

  // FIFO state register and the sticky drop flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_valid_r <= 1'b0;
      buf_valid_r  <= 1'b0;
      head_r       <= '0;
      buf_r        <= '0;
      err_drop     <= 1'b0;
    end else begin
      head_valid_r <= head_valid_n;
      buf_valid_r  <= buf_valid_n;
      head_r       <= head_n;
      buf_r        <= buf_n;
      err_drop     <= err_drop | drop_s;
    end
  end

  assign trc_valid   = head_valid_r;
  assign trc_id      = head_r.id;
  assign trc_addr    = head_r.addr;
  assign trc_cmd     = head_r.cmd;
  assign trc_data    = head_r.data;
  assign trc_latency = head_r.latency;
  assign trc_orphan  = head_r.orphan;

endmodule

// File: tb/tb_insight_dcache_resp_tracker.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences and a
// randomized phase checked against a queue-based reference model.
`timescale 1ns/1ps
module tb_insight_dcache_resp_tracker;
  localparam int SLOTS = 8;
  localparam int LAT_W = 8;

  logic        clk = 1'b0, rst_n = 1'b1;
  logic        req_valid = 1'b0, req_signed = 1'b0, resp_valid = 1'b0, trc_ready = 1'b1;
  logic [31:0] req_addr = '0, resp_data = '0;
  logic [5:0]  req_id = '0, resp_id = '0;
  logic [4:0]  req_cmd = '0;
  logic [1:0]  req_size = '0;
  logic        trc_valid, trc_orphan, err_overflow, err_dup_id, err_drop;
  logic [5:0]  trc_id;
  logic [31:0] trc_addr, trc_data;
  logic [4:0]  trc_cmd;
  logic [LAT_W-1:0] trc_latency;
  logic [3:0]  outstanding;

  insight_dcache_resp_tracker #(.SLOTS(SLOTS), .LAT_W(LAT_W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr), .req_id(req_id),
    .req_cmd(req_cmd), .req_signed(req_signed), .req_size(req_size), .resp_valid(resp_valid),
    .resp_id(resp_id), .resp_data(resp_data), .trc_valid(trc_valid), .trc_ready(trc_ready),
    .trc_id(trc_id), .trc_addr(trc_addr), .trc_cmd(trc_cmd), .trc_data(trc_data),
    .trc_latency(trc_latency), .trc_orphan(trc_orphan), .outstanding(outstanding),
    .err_overflow(err_overflow), .err_dup_id(err_dup_id), .err_drop(err_drop));

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_req(input logic [5:0] id, input logic [4:0] cmd, input logic [31:0] addr,
                        input logic [1:0] size, input logic sgn);
    req_valid = 1'b1; req_id = id; req_cmd = cmd; req_addr = addr; req_size = size; req_signed = sgn;
    step();
    req_valid = 1'b0;
  endtask

  task automatic do_resp(input logic [5:0] id, input logic [31:0] data);
    resp_valid = 1'b1; resp_id = id; resp_data = data;
    step();
    resp_valid = 1'b0;
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [5:0] id; logic [31:0] addr; logic [4:0] cmd; logic sgn; logic [1:0] size; int issued;
  } pend_t;
  typedef struct {
    logic [5:0] id; logic [31:0] addr; logic [4:0] cmd; logic [31:0] data; int lat; logic orphan;
  } rec_t;
  pend_t pend[$];
  rec_t  expq[$];
  logic  m_ovf, m_dup, m_drop;

  function automatic logic is_bearing(input logic [4:0] cmd);
    return cmd inside {5'd0, 5'd4, 5'd6, 5'd7, [5'd8:5'd15]};
  endfunction

  function automatic logic [31:0] exp_fmt(input logic [31:0] data, input logic [31:0] addr,
                                          input logic [1:0] size, input logic sgn, input logic [4:0] cmd);
    longint unsigned v, span;
    int off;
    if (!(cmd == 5'd0 || cmd == 5'd6) || size >= 2) return data;
    span = (size == 0) ? 64'd256 : 64'd65536;
    off  = (size == 0) ? int'(addr % 4) : int'((addr % 4) / 2) * 2;
    v = (longint'(data) / (64'd1 << (8 * off))) % span;
    if (sgn && v >= span / 2) v = v + 64'h1_0000_0000 - span;
    return v[31:0];
  endfunction

  task automatic model_reset();
    pend.delete(); expq.delete();
    m_ovf = 1'b0; m_dup = 1'b0; m_drop = 1'b0;
  endtask

  task automatic model_edge();
    int hit, pre, lat;
    bit dup, live;
    rec_t r;
    hit = -1; dup = 0;
    live = req_valid && is_bearing(req_cmd);
    pre = pend.size();
    for (int i = 0; i < pend.size(); i++) begin
      if (resp_valid && pend[i].id == resp_id) hit = i;
      if (live && pend[i].id == req_id) dup = 1;
    end
    if (expq.size() > 0 && trc_ready) void'(expq.pop_front());
    if (resp_valid) begin
      r.id = resp_id;
      if (hit >= 0) begin
        lat = cyc - pend[hit].issued;
        r.addr = pend[hit].addr; r.cmd = pend[hit].cmd; r.orphan = 1'b0;
        r.lat = (lat > 255) ? 255 : lat;
        r.data = exp_fmt(resp_data, pend[hit].addr, pend[hit].size, pend[hit].sgn, pend[hit].cmd);
      end else begin
        r.addr = '0; r.cmd = '0; r.lat = 0; r.orphan = 1'b1; r.data = resp_data;
      end
      if (expq.size() < 2) expq.push_back(r);
      else m_drop = 1'b1;
    end
    if (hit >= 0) pend.delete(hit);
    if (live) begin
      if (dup) m_dup = 1'b1;
      else if (pre < SLOTS) pend.push_back('{req_id, req_addr, req_cmd, req_signed, req_size, cyc});
      else m_ovf = 1'b1;
    end
  endtask

  task automatic model_check();
    chk("rnd_outstanding", outstanding, pend.size());
    chk("rnd_trc_valid", trc_valid, expq.size() != 0);
    if (expq.size() != 0) begin
      chk("rnd_rec_meta", {trc_id, trc_cmd, trc_orphan, trc_latency},
          {expq[0].id, expq[0].cmd, expq[0].orphan, 8'(expq[0].lat)});
      chk("rnd_rec_addr_data", {trc_addr, trc_data}, {expq[0].addr, expq[0].data});
    end
    chk("rnd_err_flags", {err_overflow, err_dup_id, err_drop}, {m_ovf, m_dup, m_drop});
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [5:0] id; logic [4:0] cmd; logic [31:0] addr; logic [1:0] size; logic sgn;
    logic [31:0] data; int delay; logic [31:0] exp_data;
  } vec_t;
  vec_t vecs[9];
  logic [4:0] bear_cmds[12];

  initial begin
    vecs[0] = '{6'd3, 5'd0, 32'h0000_1003, 2'd0, 1'b1, 32'h8000_0000, 3, 32'hFFFF_FF80};
    vecs[1] = '{6'd1, 5'd0, 32'h0000_2001, 2'd0, 1'b0, 32'h0000_AB00, 1, 32'h0000_00AB};
    vecs[2] = '{6'd2, 5'd6, 32'h0000_2002, 2'd1, 1'b1, 32'h8001_1234, 2, 32'hFFFF_8001};
    vecs[3] = '{6'd4, 5'd0, 32'h0000_2000, 2'd1, 1'b0, 32'h1234_F00D, 5, 32'h0000_F00D};
    vecs[4] = '{6'd5, 5'd0, 32'h0000_3004, 2'd2, 1'b1, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF};
    vecs[5] = '{6'd6, 5'd7, 32'h0000_5001, 2'd0, 1'b1, 32'h1234_5680, 4, 32'h1234_5680};
    vecs[6] = '{6'd7, 5'd8, 32'h0000_6003, 2'd0, 1'b1, 32'hCAFE_F08D, 2, 32'hCAFE_F08D};
    vecs[7] = '{6'd8, 5'd0, 32'h0000_7002, 2'd0, 1'b1, 32'h007F_0000, 3, 32'h0000_007F};
    vecs[8] = '{6'd9, 5'd0, 32'h0000_8000, 2'd3, 1'b0, 32'h89AB_CDEF, 1, 32'h89AB_CDEF};
    bear_cmds = '{5'd0, 5'd4, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15};

    // reset state, observed before any clock edge
    #1 rst_n = 1'b0;
    #2;
    chk("reset_trc_valid", trc_valid, 1'b0);
    chk("reset_outstanding", outstanding, 4'd0);
    chk("reset_err_flags", {err_overflow, err_dup_id, err_drop}, 3'b000);
    chk("reset_trc_fields", {trc_id, trc_addr, trc_cmd, trc_data, trc_latency, trc_orphan}, '0);
    step(); step();
    rst_n = 1'b1;
    step();

    // lane extraction / latency table
    for (int i = 0; i < 9; i++) begin
      do_req(vecs[i].id, vecs[i].cmd, vecs[i].addr, vecs[i].size, vecs[i].sgn);
      chk("vec_outstanding_after_req", outstanding, 4'd1);
      for (int k = 1; k < vecs[i].delay; k++) step();
      do_resp(vecs[i].id, vecs[i].data);
      chk("vec_trc_valid", trc_valid, 1'b1);
      chk("vec_trc_data", trc_data, vecs[i].exp_data);
      chk("vec_trc_latency", trc_latency, 8'(vecs[i].delay));
      chk("vec_trc_meta", {trc_id, trc_addr, trc_cmd, trc_orphan},
          {vecs[i].id, vecs[i].addr, vecs[i].cmd, 1'b0});
      chk("vec_outstanding_after_resp", outstanding, 4'd0);
      step();
      chk("vec_popped", trc_valid, 1'b0);
    end

    // orphan response
    do_resp(6'd5, 32'h5A5A_1234);
    chk("orphan_flag", trc_orphan, 1'b1);
    chk("orphan_fields", {trc_valid, trc_id, trc_addr, trc_cmd, trc_latency}, {1'b1, 6'd5, 32'h0, 5'd0, 8'd0});
    chk("orphan_data", trc_data, 32'h5A5A_1234);
    step();

    // non-response-bearing commands are ignored
    do_req(6'd33, 5'd1, 32'h100, 2'd2, 1'b0);
    do_req(6'd34, 5'd2, 32'h200, 2'd2, 1'b0);
    step();
    chk("ignored_outstanding", outstanding, 4'd0);
    chk("ignored_no_record", trc_valid, 1'b0);

    // backpressure: two held, third dropped
    trc_ready = 1'b0;
    for (int i = 10; i < 13; i++) do_req(6'(i), 5'd0, 32'h100, 2'd2, 1'b0);
    chk("bp_outstanding3", outstanding, 4'd3);
    for (int i = 10; i < 13; i++) do_resp(6'(i), 32'hA000_0000 | 32'(i));
    chk("bp_err_drop", err_drop, 1'b1);
    chk("bp_outstanding0", outstanding, 4'd0);
    step(); step();
    chk("bp_head_held", {trc_valid, trc_id, trc_data}, {1'b1, 6'd10, 32'hA000_000A});
    trc_ready = 1'b1;
    step();
    chk("bp_second", {trc_valid, trc_id, trc_data}, {1'b1, 6'd11, 32'hA000_000B});
    step();
    chk("bp_empty", trc_valid, 1'b0);

    // asynchronous reset mid-operation
    trc_ready = 1'b0;
    for (int i = 40; i < 43; i++) do_req(6'(i), 5'd0, 32'h400, 2'd2, 1'b0);
    do_resp(6'd50, 32'h1111_2222);
    chk("prereset_state", {trc_valid, outstanding}, {1'b1, 4'd3});
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_trc_valid", trc_valid, 1'b0);
    chk("async_reset_outstanding", outstanding, 4'd0);
    chk("async_reset_flags", {err_overflow, err_dup_id, err_drop}, 3'b000);
    chk("async_reset_fields", {trc_id, trc_addr, trc_data, trc_orphan}, '0);
    step();
    rst_n = 1'b1;
    trc_ready = 1'b1;
    step();
    do_resp(6'd40, 32'h4040_4040);
    chk("postreset_orphan", {trc_valid, trc_orphan, trc_id, trc_latency}, {1'b1, 1'b1, 6'd40, 8'd0});
    step();

    // overflow with nine requests, then a duplicate id
    for (int i = 20; i < 29; i++) do_req(6'(i), 5'd0, 32'h2000 + 32'(i), 2'd2, 1'b0);
    chk("ovf_outstanding", outstanding, 4'd8);
    chk("ovf_flags", {err_overflow, err_dup_id}, 2'b10);
    do_resp(6'd28, 32'h2828_2828);
    chk("ovf_ninth_orphan", {trc_valid, trc_orphan, trc_id}, {1'b1, 1'b1, 6'd28});
    do_req(6'd20, 5'd0, 32'h0, 2'd2, 1'b0);
    chk("dup_flag", err_dup_id, 1'b1);
    chk("dup_outstanding", outstanding, 4'd8);

    // randomized phase against the reference model
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    model_reset();
    step();
    for (int n = 0; n < 3000; n++) begin
      req_valid  = ($urandom_range(0, 99) < 40);
      req_cmd    = ($urandom_range(0, 99) < 70) ? bear_cmds[$urandom_range(0, 11)] : 5'($urandom_range(0, 20));
      req_id     = 6'($urandom_range(0, 15));
      req_addr   = $urandom;
      req_size   = 2'($urandom_range(0, 3));
      req_signed = 1'($urandom_range(0, 1));
      resp_valid = ($urandom_range(0, 99) < 40);
      resp_id    = (pend.size() > 0 && $urandom_range(0, 99) < 75) ?
                   pend[$urandom_range(0, pend.size() - 1)].id : 6'($urandom_range(0, 15));
      resp_data  = $urandom;
      trc_ready  = ($urandom_range(0, 99) < 60);
      model_edge();
      step();
      model_check();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/insight_dcache_resp_tracker.md
INSIGHT_DCACHE_RESP_TRACKER -- requirements
Module: insight_dcache_resp_tracker

Interface
REQ-001 SHALL have parameter SLOTS, default 8, giving the number of outstanding-request slots.
REQ-002 SHALL have parameter LAT_W, default 8, giving the latency counter width.
REQ-003 SHALL have port clock  in  1  sole clock; one clock, all state on rising edge.
REQ-004 SHALL have port reset  in  1  reset, asynchronous and active-low.
REQ-005 SHALL have port req_valid  in  1  retiring instruction issued an acknowledged cache request.
REQ-006 SHALL have port req_addr  in  32  request address.
REQ-007 SHALL have port req_id  in  6  cache transaction id.
REQ-008 SHALL have port req_cmd  in  5  transaction command encoding (M_XRD=00000 ... M_SFENCE=10100).
REQ-009 SHALL have port req_signed  in  1  load signedness.
REQ-010 SHALL have port req_size  in  2  log2 access bytes.
REQ-011 SHALL have port resp_valid  in  1  cache response this cycle.
REQ-012 SHALL have port resp_id  in  6  response transaction id.
REQ-013 SHALL have port resp_data  in  32  raw response word.
REQ-014 SHALL have port trc_valid  out  1  response trace record available.
REQ-015 SHALL have port trc_ready  in  1  consumer accepts record.
REQ-016 SHALL have ports trc_id  out  6; trc_addr  out  32; trc_cmd  out  5; trc_data  out  32; trc_latency  out  LAT_W; trc_orphan  out  1.
REQ-017 SHALL have port outstanding  out  clog2(SLOTS+1)  count of valid slots.
REQ-018 SHALL have ports err_overflow, err_dup_id, err_drop  out  1 each  sticky error flags.

Function
REQ-019 SHALL allocate a slot only for response-bearing commands: M_XRD, M_XLR, M_XSC, M_XA_SWAP, M_XA_ADD..M_XA_MAXU; all other commands are ignored.
REQ-020 SHALL allocate the lowest-index free slot, storing id, addr, cmd, signed, size, age=0.
REQ-021 SHALL, when no slot is free, drop the request and set err_overflow.
REQ-022 SHALL, when req_id matches a valid slot, drop the request and set err_dup_id.
REQ-023 SHALL increment each valid slot's age every cycle after capture, saturating at 2^LAT_W-1.
REQ-024 SHALL match resp_id against slots valid before the current edge; a match frees that slot and enqueues a record with latency = age (cycles from request to response).
REQ-025 SHALL NOT make a slot freed in cycle N allocatable before cycle N+1; a same-cycle request and response with equal id treats the response as orphan.
REQ-026 SHALL, for an unmatched response, enqueue a record with trc_orphan=1, addr=0, cmd=0, latency=0, data=resp_data unmodified.
REQ-027 SHALL, for M_XRD/M_XLR, extract lanes by addr: size0 byte data[8*addr[1:0]+:8], size1 half data[16*addr[1]+:16], size2/3 full word; sign-extend if signed else zero-extend.
REQ-028 SHALL pass resp_data unmodified for M_XSC and atomics.
REQ-029 SHALL buffer records in a 2-entry FIFO; trc_valid asserts the cycle after resp_valid when the FIFO is empty.
REQ-030 SHALL hold all trc_* stable while trc_valid=1 and trc_ready=0; pop on trc_valid&trc_ready.
REQ-031 SHALL, when the FIFO is full and not popping that cycle, discard the new record, still free the slot, and set err_drop; a simultaneous pop and push is permitted.
REQ-032 SHALL update outstanding registered, reflecting allocations and frees of the prior edge.

Reset
REQ-033 SHALL, on reset assertion, immediately invalidate all slots, empty the FIFO, and drive trc_valid=0, all trc_* =0, outstanding=0, and all error flags=0.
REQ-034 SHALL clear error flags only by reset.
REQ-035 SHALL discard any in-flight transactions on mid-operation reset; responses after release for pre-reset ids are orphans.

Verification
REQ-036 SHALL verify: M_XRD id 3, addr 0x1003, size0, signed; resp id 3 data 0x80000000 three cycles later -> trc_data 0xFFFFFF80, latency 3, orphan 0.
REQ-037 SHALL verify: 9 distinct M_XRD with no responses -> outstanding=8, err_overflow=1, ninth id never traced.
REQ-038 SHALL verify: resp id 5 with no request -> trc_orphan=1, trc_addr=0, trc_data=resp_data.
REQ-039 SHALL verify: trc_ready=0, three matched responses -> two records held stable, third dropped, err_drop=1, outstanding decremented by 3.
REQ-040 SHALL verify: M_XWR and M_PFR requests -> outstanding stays 0, no records.
REQ-041 SHALL verify: reset asserted with outstanding=3 and trc_valid=1 -> outputs zero without a clock edge; post-release resp for old id -> orphan.
